sobel_frame_scheduler: RTL and testbench
========================================

// Module: sobel_frame_scheduler
// PURPOSE
//  Frame-granular 2-way arbiter in front of the single sobel_pipeline instance.
//  - Grants one requester stream the pipeline for a whole WIDTH_P*HEIGHT_P frame.
//  - Tags returned pipeline pixels with the owner id.
//  - Waits for the pipeline to drain before re-arbitrating, so line buffers never mix frames.
// PARAMETERS
//  WIDTH_P          640   frame width in pixels
//  HEIGHT_P         480   frame height in pixels
//  CHANNELS_P       1     bytes per pixel; pixel width PW = CHANNELS_P*8
//  DRAIN_TIMEOUT_P  2048  idle-output cycles in DRAIN before the watchdog fires (SOBEL_SCHED_WDOG_EN only)
// PORTS
//  clk_i         in   1        clock
//  reset_i       in   1        synchronous, active-high reset
//  req_valid_i   in   2        per-requester pixel valid
//  req_pixel0_i  in   PW       requester 0 pixel
//  req_pixel1_i  in   PW       requester 1 pixel
//  req_ready_o   out  2        per-requester ready; at most one bit high
//  pipe_valid_o  out  1        to sobel_pipeline valid_i
//  pipe_pixel_o  out  PW       to sobel_pipeline pixel_i
//  pipe_valid_i  in   1        from sobel_pipeline valid_o
//  pipe_pixel_i  in   PW       from sobel_pipeline pixel_o
//  out_valid_o   out  1        filtered pixel valid; sink must always accept, no backpressure
//  out_pixel_o   out  PW       filtered pixel
//  out_id_o      out  1        owner of out_pixel_o
//  out_last_o    out  1        marks the last pixel of the frame
//  busy_o        out  1        high in any state other than IDLE
//  frame_done_o  out  1        1-cycle pulse when a frame completes (or is aborted)
//  timeout_o     out  1        sticky drain-watchdog flag
// BEHAVIOUR
//  - Reset:
//    - State goes to IDLE; last_grant = 1, so requester 0 wins first.
//    - All outputs are 0. Pixel buses are also 0. Counters clear.
//  - IDLE:
//    - req_ready_o = 0.
//    - If any req_valid_i bit is high, grant round-robin: a lone requester wins; if both, the one != last_grant wins.
//    - Go to STREAM the next cycle.
//  - STREAM:
//    - req_ready_o[g] = 1 only for grant g.
//    - Accept when req_valid_i[g] && req_ready_o[g].
//    - Each accept registers pipe_valid_o = 1 and pipe_pixel_o = pixel (1-cycle latency). Otherwise pipe_valid_o = 0.
//    - Gaps on req_valid_i are allowed; the grant is held for the whole frame (no mid-frame switch).
//    - Inputs from the non-granted requester are ignored and left unaccepted.
//    - in_cnt counts accepts. On the accept with in_cnt == WIDTH_P*HEIGHT_P-1, ready drops the next cycle and state goes to DRAIN.
//  - DRAIN:
//    - req_ready_o = 0 and pipe_valid_o = 0 (after the final registered pixel).
//    - Completion is exactly out_cnt == WIDTH_P*HEIGHT_P; then go to IDLE.
//    - On the exit cycle: frame_done_o pulses, last_grant = g, counters clear.
//  - Return path (STREAM and DRAIN):
//    - out_valid_o, out_pixel_o and out_id_o = g are registered from pipe_valid_i/pipe_pixel_i (1-cycle latency).
//    - out_cnt increments per pipe_valid_i.
//    - out_last_o is high with the WIDTH_P*HEIGHT_P-th output.
//    - The pipeline may return pixels while STREAM is still accepting; both counters run concurrently.
//  - pipe_valid_i in IDLE: dropped, no out_valid_o, no count.
//  - Counter width: $clog2(WIDTH_P*HEIGHT_P+1). No wrap is possible within a frame.
//  - Reset mid-frame:
//    - Immediate IDLE with no frame_done_o pulse.
//    - The pipeline shares reset_i, so partial frames are discarded.
// CONFIGURATION
//  - Macro SOBEL_SCHED_WDOG_EN.
//  - Defined:
//    - A DRAIN counter clears on every pipe_valid_i.
//    - When it reaches DRAIN_TIMEOUT_P: force IDLE, pulse frame_done_o, set timeout_o (sticky until reset_i). out_last_o is not asserted.
//  - Undefined: no timer; DRAIN waits indefinitely; timeout_o is tied 0.
// STRUCTURE
//  - Package sobel_sched_pkg holds:
//    - sched_state_e {IDLE, STREAM, DRAIN}
//    - typedef req_id_t (1 bit)
//    - localparam NUM_REQ = 2
//  - Sub-module sobel_rr_arbiter: 2-way round-robin grant from req_valid_i and last_grant, combinational.
// TESTING  (WIDTH_P=8, HEIGHT_P=4, frame = 32 pixels; pipeline model returns in-order pixels)
//  1. Only req0 streams 32 pixels 0x00..0x1F.
//     -> req_ready_o=01 for exactly 32 accepts.
//     -> pipe_valid_o mirrors each accept 1 cycle later.
//     -> 32 outputs with out_id_o=0; out_last_o on the 32nd.
//     -> frame_done_o pulses once; busy_o falls.
//  2. req0 and req1 both valid out of reset.
//     -> req0 frame first, then req1.
//     -> Both still valid again: req0 is granted next (alternation).
//  3. req0 valid toggles 1/0 every cycle.
//     -> 32 accepts over about 64 cycles.
//     -> req_ready_o[1] stays 0 throughout despite req1 being valid.
//  4. reset_i asserted after 10 accepts.
//     -> Next cycle all outputs 0; no frame_done_o.
//     -> A new frame after reset completes normally.
//  5. SOBEL_SCHED_WDOG_EN, DRAIN_TIMEOUT_P=16, model returns only 20 pixels.
//     -> 16 cycles after the last output: frame_done_o pulse, timeout_o=1 (stays set), no out_last_o.
//  6. pipe_valid_i pulsed in IDLE.
//     -> out_valid_o stays 0; next frame out_cnt starts at 0.

Source files
------------

// File: rtl/sobel_sched_pkg.sv
// Shared types for the sobel frame scheduler.
package sobel_sched_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} sched_state_e;

  typedef logic req_id_t;

  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/sobel_rr_arbiter.sv
// Combinational 2-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module sobel_rr_arbiter
  import sobel_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  req_id_t            last_grant,
  output logic               grant_valid,
  output req_id_t            grant_id
);

  always_comb begin
    grant_valid = |req_valid;
    grant_id    = last_grant;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = last_grant;
    endcase
  end

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame-granular 2-way arbiter in front of a single sobel_pipeline; tags returned pixels with the owner id.
// Optional drain watchdog enabled by defining SOBEL_SCHED_WDOG_EN.
module sobel_frame_scheduler
  import sobel_sched_pkg::*;
#(
  parameter int unsigned WIDTH_P         = 640,
  parameter int unsigned HEIGHT_P        = 480,
  parameter int unsigned CHANNELS_P      = 1,
  parameter int unsigned DRAIN_TIMEOUT_P = 2048
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [CHANNELS_P*8-1:0] req_pixel0_i,
  input  logic [CHANNELS_P*8-1:0] req_pixel1_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    pipe_valid_o,
  output logic [CHANNELS_P*8-1:0] pipe_pixel_o,
  input  logic                    pipe_valid_i,
  input  logic [CHANNELS_P*8-1:0] pipe_pixel_i,
  output logic                    out_valid_o,
  output logic [CHANNELS_P*8-1:0] out_pixel_o,
  output logic                    out_id_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    timeout_o
);

  localparam int unsigned FRAME_PIX = WIDTH_P * HEIGHT_P;
  localparam int unsigned CW        = $clog2(FRAME_PIX + 1);
  localparam int unsigned WW        = $clog2(DRAIN_TIMEOUT_P + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_PIX - 1);
  localparam logic [CW-1:0] FRAME_END = CW'(FRAME_PIX);

`ifdef SOBEL_SCHED_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  sched_state_e state_q, state_d;
  req_id_t      grant_q, last_grant_q, arb_id;
  logic         arb_valid, accept, out_capture, drain_done, wdog_fire, timeout_q;
  logic [CW-1:0] in_cnt_q, out_cnt_q;
  logic [WW-1:0] wdog_q;

  sobel_rr_arbiter u_arb (
    .req_valid   (req_valid_i),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  assign out_capture = (state_q != IDLE) && pipe_valid_i;
  assign wdog_fire   = WDOG_EN && (state_q == DRAIN) && (wdog_q == WW'(DRAIN_TIMEOUT_P));
  assign timeout_o   = timeout_q;

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    accept       = 1'b0;
    drain_done   = 1'b0;
    busy_o       = (state_q != IDLE);
    case (state_q)
      IDLE: if (arb_valid) state_d = STREAM;
      STREAM: begin
        req_ready_o[grant_q] = 1'b1;
        accept               = req_valid_i[grant_q];
        if (accept && (in_cnt_q == LAST_IDX)) state_d = DRAIN;
      end
      DRAIN: begin
        drain_done = (out_cnt_q == FRAME_END) || wdog_fire;
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    frame_done_o = drain_done;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      pipe_valid_o <= 1'b0;
      pipe_pixel_o <= '0;
      out_valid_o  <= 1'b0;
      out_pixel_o  <= '0;
      out_id_o     <= 1'b0;
      out_last_o   <= 1'b0;
    end else begin
      if (state_q == IDLE && arb_valid) grant_q <= arb_id;
      pipe_valid_o <= accept;
      if (accept) begin
        pipe_pixel_o <= grant_q ? req_pixel1_i : req_pixel0_i;
        in_cnt_q     <= in_cnt_q + 1'b1;
      end
      out_valid_o <= out_capture;
      out_last_o  <= out_capture && (out_cnt_q == LAST_IDX);
      if (out_capture) begin
        out_pixel_o <= pipe_pixel_i;
        out_id_o    <= grant_q;
        out_cnt_q   <= out_cnt_q + 1'b1;
      end
      if (drain_done) begin
        last_grant_q <= grant_q;
        in_cnt_q     <= '0;
        out_cnt_q    <= '0;
      end
    end
  end

  // Idle-output timer: only counts in DRAIN, restarts on every returned pixel.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != DRAIN || pipe_valid_i) wdog_q <= '0;
      else if (!wdog_fire)                  wdog_q <= wdog_q + 1'b1;
      if (wdog_fire) timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed self-checking bench for sobel_frame_scheduler (8x4 frames, 3-stage inverting pipeline model).
module tb_sobel_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [1:0] req_valid_i = '0;
  logic [7:0] req_pixel0_i = '0, req_pixel1_i = '0;
  logic [1:0] req_ready_o;
  logic       pipe_valid_o, pipe_valid_i;
  logic [7:0] pipe_pixel_o, pipe_pixel_i;
  logic       out_valid_o, out_id_o, out_last_o, busy_o, frame_done_o, timeout_o;
  logic [7:0] out_pixel_o;

  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  sobel_frame_scheduler #(
    .WIDTH_P         (8),
    .HEIGHT_P        (4),
    .CHANNELS_P      (1),
    .DRAIN_TIMEOUT_P (16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_pixel0_i (req_pixel0_i),
    .req_pixel1_i (req_pixel1_i),
    .req_ready_o  (req_ready_o),
    .pipe_valid_o (pipe_valid_o),
    .pipe_pixel_o (pipe_pixel_o),
    .pipe_valid_i (pipe_valid_i),
    .pipe_pixel_i (pipe_pixel_i),
    .out_valid_o  (out_valid_o),
    .out_pixel_o  (out_pixel_o),
    .out_id_o     (out_id_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .timeout_o    (timeout_o)
  );

  // Pipeline model: 3-cycle latency, returns inverted pixels, optionally truncated.
  logic [2:0] dly_v;
  logic [7:0] dly_p [3];
  logic       inject = 1'b0;
  logic [7:0] inject_pix = '0;
  int         ret_cnt, ret_limit = 1000;

  always @(posedge clk) begin
    if (reset_i) begin
      dly_v   <= '0;
      ret_cnt <= 0;
    end else begin
      dly_v    <= {dly_v[1:0], pipe_valid_o && (ret_cnt < ret_limit)};
      dly_p[0] <= pipe_pixel_o ^ 8'hFF;
      dly_p[1] <= dly_p[0];
      dly_p[2] <= dly_p[1];
      if (pipe_valid_o) ret_cnt <= ret_cnt + 1;
    end
  end

  assign pipe_valid_i = dly_v[2] | inject;
  assign pipe_pixel_i = inject ? inject_pix : dly_p[2];

  // Observation counters, sampled on the falling edge and cleared while reset is high.
  int cnt_acc0, cnt_acc1, cnt_pipe, cnt_out0, cnt_out1, cnt_last, cnt_done;
  int last_idx, out_idx, seq_err, lat_err, rdy0_cyc, rdy1_cyc, both_rdy;
  int done_id [4];
  logic done_last;
  logic prev_acc = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_pix = '0;
  logic [7:0] exp_q [$];
  logic [1:0] acc;

  always @(negedge clk) begin
    if (pipe_valid_o !== (prev_acc && !prev_rst)) lat_err++;
    else if (pipe_valid_o && pipe_pixel_o !== prev_pix) lat_err++;
    if (pipe_valid_o) cnt_pipe++;
    if (out_valid_o) begin
      out_idx++;
      if (out_id_o) cnt_out1++; else cnt_out0++;
      if (exp_q.size() == 0) seq_err++;
      else if (out_pixel_o !== exp_q.pop_front()) seq_err++;
    end
    if (out_last_o) begin
      cnt_last++;
      last_idx = out_idx;
    end
    if (frame_done_o) begin
      if (cnt_done < 4) done_id[cnt_done] = int'(out_id_o);
      done_last = out_last_o;
      cnt_done++;
    end
    if (pipe_valid_o) exp_q.push_back(pipe_pixel_o ^ 8'hFF);
    acc = req_valid_i & req_ready_o;
    cnt_acc0 += int'(acc[0]);
    cnt_acc1 += int'(acc[1]);
    rdy0_cyc += int'(req_ready_o[0]);
    rdy1_cyc += int'(req_ready_o[1]);
    if (req_ready_o == 2'b11) both_rdy++;
    prev_acc = |acc;
    prev_pix = req_ready_o[1] ? req_pixel1_i : req_pixel0_i;
    prev_rst = reset_i;
    if (reset_i) begin
      cnt_acc0 = 0; cnt_acc1 = 0; cnt_pipe = 0; cnt_out0 = 0; cnt_out1 = 0;
      cnt_last = 0; cnt_done = 0; last_idx = 0; out_idx = 0; seq_err = 0;
      lat_err = 0; rdy0_cyc = 0; rdy1_cyc = 0; both_rdy = 0; done_last = 1'b0;
      for (int i = 0; i < 4; i++) done_id[i] = -1;
      exp_q.delete();
    end
  end

`define CHECK(TAG, OBS, EXP) \
    n_assert++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0d expected %0d", TAG, OBS, EXP); \
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    req_valid_i = '0;
    inject      = 1'b0;
    repeat (2) tick();
    reset_i = 1'b0;
    tick();
  endtask

  // Streams up to lim0/lim1 pixels per requester until `target` frames complete or the budget runs out.
  task automatic run_frames(input bit en0, input bit en1, input int lim0, input int lim1,
                            input bit tog0, input int target, input int budget);
    int p0 = 0, p1 = 0;
    bit a0, a1;
    for (int k = 0; k < budget; k++) begin
      req_valid_i[0] = en0 && (p0 < lim0) && (!tog0 || (k % 2 == 0));
      req_valid_i[1] = en1 && (p1 < lim1);
      req_pixel0_i   = 8'(p0);
      req_pixel1_i   = 8'(8'h80 + p1);
      a0 = req_valid_i[0] && req_ready_o[0];
      a1 = req_valid_i[1] && req_ready_o[1];
      tick();
      p0 += int'(a0);
      p1 += int'(a1);
      if (cnt_done >= target) break;
    end
    req_valid_i = '0;
    `CHECK("frames_completed", cnt_done, target)
  endtask

  initial begin
    int p;
    bit a;

    // Reset state
    do_reset();
    `CHECK("rst_ready", req_ready_o, 2'b00)
    `CHECK("rst_outputs", {pipe_valid_o, out_valid_o, out_id_o, out_last_o, busy_o, frame_done_o, timeout_o}, 7'b0)
    `CHECK("rst_pixels", {pipe_pixel_o, out_pixel_o}, 16'h0000)

    // 1: req0 alone, one frame
    run_frames(1'b1, 1'b0, 32, 0, 1'b0, 1, 200);
    `CHECK("t1_acc0", cnt_acc0, 32)
    `CHECK("t1_acc1", cnt_acc1, 0)
    `CHECK("t1_pipe_cnt", cnt_pipe, 32)
    `CHECK("t1_pipe_latency", lat_err, 0)
    `CHECK("t1_out_id0", cnt_out0, 32)
    `CHECK("t1_out_id1", cnt_out1, 0)
    `CHECK("t1_out_data", seq_err, 0)
    `CHECK("t1_last_cnt", cnt_last, 1)
    `CHECK("t1_last_idx", last_idx, 32)
    `CHECK("t1_done_with_last", done_last, 1'b1)
    `CHECK("t1_busy_fall", busy_o, 1'b0)

    // 2: both requesters valid out of reset; alternation
    do_reset();
    run_frames(1'b1, 1'b1, 64, 32, 1'b0, 3, 400);
    `CHECK("t2_first_owner", done_id[0], 0)
    `CHECK("t2_second_owner", done_id[1], 1)
    `CHECK("t2_third_owner", done_id[2], 0)
    `CHECK("t2_acc0", cnt_acc0, 64)
    `CHECK("t2_acc1", cnt_acc1, 32)
    `CHECK("t2_out_id0", cnt_out0, 64)
    `CHECK("t2_out_id1", cnt_out1, 32)
    `CHECK("t2_out_data", seq_err, 0)
    `CHECK("t2_last_cnt", cnt_last, 3)
    `CHECK("t2_one_hot_ready", both_rdy, 0)
    `CHECK("t2_pipe_latency", lat_err, 0)

    // 3: req0 toggles every cycle, req1 constantly valid
    do_reset();
    run_frames(1'b1, 1'b1, 32, 32, 1'b1, 1, 300);
    `CHECK("t3_acc0", cnt_acc0, 32)
    `CHECK("t3_ready0_cycles", rdy0_cyc, 64)
    `CHECK("t3_ready1_never", rdy1_cyc, 0)
    `CHECK("t3_acc1", cnt_acc1, 0)
    `CHECK("t3_out_data", seq_err, 0)
    `CHECK("t3_pipe_latency", lat_err, 0)

    // 4: reset after 10 accepts, then a clean frame
    do_reset();
    p = 0;
    for (int k = 0; k < 40; k++) begin
      req_valid_i[0] = 1'b1;
      req_pixel0_i   = 8'(p);
      a = req_ready_o[0];
      tick();
      p += int'(a);
      if (p == 10) break;
    end
    `CHECK("t4_ten_accepts", p, 10)
    reset_i     = 1'b1;
    req_valid_i = '0;
    tick();
    `CHECK("t4_outputs_zero", {req_ready_o, pipe_valid_o, out_valid_o, out_last_o, busy_o, frame_done_o}, 7'b0)
    `CHECK("t4_pixels_zero", {pipe_pixel_o, out_pixel_o}, 16'h0000)
    reset_i = 1'b0;
    repeat (20) tick();
    `CHECK("t4_no_done", cnt_done, 0)
    `CHECK("t4_no_out", cnt_out0 + cnt_out1, 0)
    run_frames(1'b1, 1'b0, 32, 0, 1'b0, 1, 200);
    `CHECK("t4_new_acc0", cnt_acc0, 32)
    `CHECK("t4_new_last_idx", last_idx, 32)
    `CHECK("t4_new_out_data", seq_err, 0)

    // 6: pipe_valid_i pulsed in IDLE
    do_reset();
    inject_pix = 8'h55;
    inject     = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();
    `CHECK("t6_idle_no_out", cnt_out0 + cnt_out1, 0)
    `CHECK("t6_idle_busy", busy_o, 1'b0)
    run_frames(1'b0, 1'b1, 0, 32, 1'b0, 1, 200);
    `CHECK("t6_owner", done_id[0], 1)
    `CHECK("t6_out_id1", cnt_out1, 32)
    `CHECK("t6_last_idx", last_idx, 32)
    `CHECK("t6_out_data", seq_err, 0)

`ifdef SOBEL_SCHED_WDOG_EN
    // 5: truncated return, watchdog ends the frame
    do_reset();
    ret_limit = 20;
    run_frames(1'b1, 1'b0, 32, 0, 1'b0, 1, 300);
    ret_limit = 1000;
    `CHECK("t5_out_cnt", cnt_out0, 20)
    `CHECK("t5_no_last", cnt_last, 0)
    `CHECK("t5_timeout", timeout_o, 1'b1)
    repeat (5) tick();
    `CHECK("t5_timeout_sticky", timeout_o, 1'b1)
`else
    `CHECK("timeout_tied_low", timeout_o, 1'b0)
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
